// File: rtl/rx_iq_pkg.sv
// Shared defaults, width helper and fill-zone encoding for the receive-side
// I/Q rate adapter.
package rx_iq_pkg;

    // Default geometry of the adapter.
    localparam int unsigned DEF_IQ_DATA_WIDTH = 16;
    localparam int unsigned DEF_NUM_CH        = 2;
    localparam int unsigned DEF_FIFO_DEPTH    = 32;
    localparam int unsigned DEF_CNT_WIDTH     = 6;

    // Default run-time register values for a depth-32 FIFO and a
    // 100 MHz clock feeding a 20 Msps baseband (period 5, top 4).
    localparam int unsigned DEF_LOW_THRESH    = 11;
    localparam int unsigned DEF_HIGH_THRESH   = 22;
    localparam int unsigned DEF_COUNT_TOP_NOM = 4;

    // Where the FIFO fill level sits relative to the drift thresholds.
    typedef enum logic [1:0] {
        FILL_LOW,
        FILL_MID,
        FILL_HIGH
    } fill_zone_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/rx_iq_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// The head entry is always visible on rd_data while the FIFO is non-empty.
module rx_iq_sync_fifo
    import rx_iq_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 2 * DEF_NUM_CH * DEF_IQ_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_FIFO_DEPTH,
    localparam int unsigned AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Fall-through head and status decode.
    always_comb begin
        rd_data = mem[rd_ptr];
        empty   = (count == '0);
        full    = (count[AW] == 1'b1);
    end

endmodule

// File: rtl/rx_iq_rate_adapt.sv
// Receive-side I/Q rate adapter: buffers front-end samples for NUM_CH
// antennas and releases them at a paced, fill-level compensated rate.
// Optional build macro RX_IQ_STATS_EN adds saturating 16-bit overflow and
// underflow event counters; without it ovf_cnt/udf_cnt are constant zero.
module rx_iq_rate_adapt
    import rx_iq_pkg::*;
#(
    parameter  int unsigned IQ_DATA_WIDTH = DEF_IQ_DATA_WIDTH,
    parameter  int unsigned NUM_CH        = DEF_NUM_CH,
    parameter  int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter  int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
    localparam int unsigned IQ_W          = 2 * NUM_CH * IQ_DATA_WIDTH,
    localparam int unsigned FC_W          = clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IQ_W-1:0]      s_iq,
    input  logic                 s_valid,
    input  logic                 fifo_in_en,
    input  logic                 fifo_out_en,
    input  logic                 pace_bypass,
    input  logic [CNT_WIDTH-1:0] count_top_nom,
    input  logic                 frac_mode,
    input  logic [FC_W-1:0]      low_thresh,
    input  logic [FC_W-1:0]      high_thresh,
    input  logic                 valid_delay_sel,
    input  logic                 clear_flags,
    output logic [IQ_W-1:0]      m_iq,
    output logic                 m_valid,
    output logic [FC_W-1:0]      fifo_count,
    output logic                 fifo_emptyn,
    output logic                 ovf_flag,
    output logic                 udf_flag,
    output logic [15:0]          ovf_cnt,
    output logic [15:0]          udf_cnt
);

    localparam logic [CNT_WIDTH:0]   TOP_MAX = {1'b0, {CNT_WIDTH{1'b1}}};
    localparam logic [CNT_WIDTH-1:0] TOP_MIN = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [IQ_W-1:0]      head;
    logic                 empty;
    logic                 full;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] counter_top;
    logic [CNT_WIDTH-1:0] top_next;
    logic [CNT_WIDTH:0]   top_calc;
    logic [CNT_WIDTH:0]   nom_ext;
    logic                 alt;
    logic                 cnt_zero;
    logic                 tick;
    logic                 rd;
    logic                 wr;
    logic                 wr_try;
    logic                 ovf_ev;
    logic                 udf_ev;
    logic [IQ_W-1:0]      m_iq_q;
    logic                 m_valid_q;
    fill_zone_e           zone;

    rx_iq_sync_fifo #(
        .DATA_WIDTH (IQ_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data (s_iq),
        .rd_en   (rd),
        .rd_data (head),
        .count   (fifo_count),
        .empty   (empty),
        .full    (full)
    );

    // Read/write strobes and overflow/underflow event decode.
    always_comb begin
        cnt_zero    = (cnt == '0);
        tick        = cnt_zero | pace_bypass;
        rd          = tick & fifo_out_en & ~empty;
        wr_try      = s_valid & fifo_in_en;
        wr          = wr_try & (~full | rd);
        ovf_ev      = wr_try & full & ~rd;
        udf_ev      = cnt_zero & fifo_out_en & empty & ~pace_bypass;
        fifo_emptyn = ~empty;
    end

    // Classify the fill level; the high zone wins if thresholds cross.
    always_comb begin
        zone = FILL_MID;
        if (fifo_count >= high_thresh) begin
            zone = FILL_HIGH;
        end else if (fifo_count < low_thresh) begin
            zone = FILL_LOW;
        end
    end

    // Next pacing period top, saturated into 1..2^CNT_WIDTH-1.
    always_comb begin
        nom_ext  = {1'b0, count_top_nom};
        top_calc = nom_ext;
        case (zone)
            FILL_LOW: begin
                top_calc = nom_ext + 1'b1;
            end
            FILL_HIGH: begin
                if (!frac_mode) begin
                    top_calc = (count_top_nom == '0) ? '0 : nom_ext - 1'b1;
                end
            end
            default: begin
                if (frac_mode && alt) begin
                    top_calc = nom_ext + 1'b1;
                end
            end
        endcase
        if (top_calc == '0) begin
            top_next = TOP_MIN;
        end else if (top_calc > TOP_MAX) begin
            top_next = '1;
        end else begin
            top_next = top_calc[CNT_WIDTH-1:0];
        end
    end

    // Pacing counter; the period top is re-evaluated at each wrap to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            counter_top <= count_top_nom;
            alt         <= 1'b0;
        end else begin
            cnt <= (cnt >= counter_top) ? '0 : cnt + 1'b1;
            if (cnt_zero) begin
                counter_top <= top_next;
                alt         <= ~alt;
            end
        end
    end

    // Sticky flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            udf_flag <= 1'b0;
        end else begin
            if (ovf_ev) begin
                ovf_flag <= 1'b1;
            end else if (clear_flags) begin
                ovf_flag <= 1'b0;
            end
            if (udf_ev) begin
                udf_flag <= 1'b1;
            end else if (clear_flags) begin
                udf_flag <= 1'b0;
            end
        end
    end

`ifdef RX_IQ_STATS_EN
    // Saturating event counters, cleared together with the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
            udf_cnt <= '0;
        end else if (clear_flags) begin
            ovf_cnt <= {15'd0, ovf_ev};
            udf_cnt <= {15'd0, udf_ev};
        end else begin
            if (ovf_ev && (ovf_cnt != 16'hFFFF)) begin
                ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (udf_ev && (udf_cnt != 16'hFFFF)) begin
                udf_cnt <= udf_cnt + 1'b1;
            end
        end
    end
`else
    // Statistics not built: counters read as zero.
    always_comb begin
        ovf_cnt = '0;
        udf_cnt = '0;
    end
`endif

    // Registered output path: capture the head on each read.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_iq_q    <= '0;
            m_valid_q <= 1'b0;
        end else begin
            m_valid_q <= rd;
            if (rd) begin
                m_iq_q <= head;
            end
        end
    end

    // Output select between registered and fall-through paths.
    always_comb begin
        m_iq    = valid_delay_sel ? head : m_iq_q;
        m_valid = valid_delay_sel ? rd   : m_valid_q;
    end

endmodule

// File: tb/tb_rx_iq_rate_adapt.sv
// Self-checking bench for rx_iq_rate_adapt: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_rx_iq_rate_adapt;
    import rx_iq_pkg::*;

    localparam int unsigned W     = DEF_IQ_DATA_WIDTH;
    localparam int unsigned NCH   = DEF_NUM_CH;
    localparam int unsigned DEPTH = DEF_FIFO_DEPTH;
    localparam int unsigned CW    = DEF_CNT_WIDTH;
    localparam int unsigned IQW   = 2 * NCH * W;
    localparam int unsigned FCW   = clog2(DEPTH) + 1;
    localparam int unsigned TOPMX = (1 << CW) - 1;
`ifdef RX_IQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [IQW-1:0] s_iq;
    logic           s_valid, fifo_in_en, fifo_out_en, pace_bypass;
    logic [CW-1:0]  count_top_nom;
    logic           frac_mode;
    logic [FCW-1:0] low_thresh, high_thresh;
    logic           valid_delay_sel, clear_flags;
    logic [IQW-1:0] m_iq;
    logic           m_valid;
    logic [FCW-1:0] fifo_count;
    logic           fifo_emptyn, ovf_flag, udf_flag;
    logic [15:0]    ovf_cnt, udf_cnt;

    always #5 clk = ~clk;

    rx_iq_rate_adapt #(
        .IQ_DATA_WIDTH (W),
        .NUM_CH        (NCH),
        .FIFO_DEPTH    (DEPTH),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .s_iq            (s_iq),
        .s_valid         (s_valid),
        .fifo_in_en      (fifo_in_en),
        .fifo_out_en     (fifo_out_en),
        .pace_bypass     (pace_bypass),
        .count_top_nom   (count_top_nom),
        .frac_mode       (frac_mode),
        .low_thresh      (low_thresh),
        .high_thresh     (high_thresh),
        .valid_delay_sel (valid_delay_sel),
        .clear_flags     (clear_flags),
        .m_iq            (m_iq),
        .m_valid         (m_valid),
        .fifo_count      (fifo_count),
        .fifo_emptyn     (fifo_emptyn),
        .ovf_flag        (ovf_flag),
        .udf_flag        (udf_flag),
        .ovf_cnt         (ovf_cnt),
        .udf_cnt         (udf_cnt)
    );

    // Reference model state.
    logic [IQW-1:0] q[$];
    int unsigned    m_cnt, m_top, m_ovf_n, m_udf_n;
    bit             m_alt, m_ovf, m_udf, m_reg_valid;
    logic [IQW-1:0] m_reg_iq;

    int unsigned    cyc;
    int unsigned    rd_log[$];
    int unsigned    n_checks, n_pass, n_fail;
    bit             chk_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Period top chosen from the fill level, saturated into 1..2^CW-1.
    function automatic int unsigned model_top(input int unsigned fill, input int unsigned nom,
                                              input bit frac, input bit alt,
                                              input int unsigned lo, input int unsigned hi);
        int t;
        if (fill >= hi)      t = frac ? int'(nom) : int'(nom) - 1;
        else if (fill < lo)  t = int'(nom) + 1;
        else                 t = (frac && alt) ? int'(nom) + 1 : int'(nom);
        if (t < 1)           t = 1;
        if (t > int'(TOPMX)) t = int'(TOPMX);
        return int'(t);
    endfunction

    // One clock: check DUT against the model, then advance the model.
    task automatic step();
        bit m_empty, m_full, m_rd, wr_try, ovf_ev, udf_ev;
        int unsigned fill, old_top;
        #1;
        fill    = q.size();
        m_empty = (fill == 0);
        m_full  = (fill == DEPTH);
        m_rd    = ((m_cnt == 0) || pace_bypass) && fifo_out_en && !m_empty;
        if (chk_en) begin
            chk("fifo_count", fifo_count, fill);
            chk("fifo_emptyn", fifo_emptyn, !m_empty);
            chk("ovf_flag", ovf_flag, m_ovf);
            chk("udf_flag", udf_flag, m_udf);
            chk("ovf_cnt", ovf_cnt, m_ovf_n);
            chk("udf_cnt", udf_cnt, m_udf_n);
            if (valid_delay_sel) begin
                chk("m_valid_comb", m_valid, m_rd);
                if (!m_empty) chk("m_iq_comb", m_iq, q[0]);
            end else begin
                chk("m_valid_reg", m_valid, m_reg_valid);
                chk("m_iq_reg", m_iq, m_reg_iq);
            end
            if (m_valid === 1'b1) rd_log.push_back(cyc);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0; m_top = count_top_nom; m_alt = 0;
            m_ovf = 0; m_udf = 0; m_ovf_n = 0; m_udf_n = 0;
            m_reg_iq = '0; m_reg_valid = 0;
        end else begin
            wr_try = s_valid && fifo_in_en;
            ovf_ev = wr_try && m_full && !m_rd;
            udf_ev = (m_cnt == 0) && fifo_out_en && m_empty && !pace_bypass;
            m_reg_valid = m_rd;
            if (m_rd) m_reg_iq = q.pop_front();
            if (wr_try && !ovf_ev) q.push_back(s_iq);
            if (ovf_ev) m_ovf = 1; else if (clear_flags) m_ovf = 0;
            if (udf_ev) m_udf = 1; else if (clear_flags) m_udf = 0;
            if (STATS) begin
                if (clear_flags) begin
                    m_ovf_n = ovf_ev; m_udf_n = udf_ev;
                end else begin
                    if (ovf_ev && m_ovf_n < 65535) m_ovf_n++;
                    if (udf_ev && m_udf_n < 65535) m_udf_n++;
                end
            end
            old_top = m_top;
            if (m_cnt == 0) begin
                m_top = model_top(fill, count_top_nom, frac_mode, m_alt, low_thresh, high_thresh);
                m_alt = !m_alt;
            end
            m_cnt = (m_cnt == old_top) ? 0 : m_cnt + 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        s_valid = 0; fifo_in_en = 0; fifo_out_en = 0; pace_bypass = 0;
        clear_flags = 0; s_iq = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic preload(input int unsigned n);
        fifo_out_en = 0; fifo_in_en = 1;
        for (int unsigned i = 0; i < n; i++) begin
            s_valid = 1; s_iq = {$urandom, $urandom};
            step();
        end
        s_valid = 0;
    endtask

    initial begin
        int unsigned sel, pv, po, seen;
        n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0; chk_en = 0;
        count_top_nom = CW'(DEF_COUNT_TOP_NOM);
        low_thresh = FCW'(DEF_LOW_THRESH); high_thresh = FCW'(DEF_HIGH_THRESH);
        frac_mode = 0; valid_delay_sel = 0;
        do_reset();
        chk_en = 1;

        // Reset state.
        chk("reset_count", fifo_count, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_iq", m_iq, 0);
        chk("reset_flags", {ovf_flag, udf_flag}, 0);

        // Balanced in/out at fill 15: period 5, occupancy constant.
        do_reset();
        preload(15);
        fifo_out_en = 1; rd_log.delete();
        for (int i = 0; i < 60; i++) begin
            s_valid = (m_cnt == 0); s_iq = {$urandom, $urandom};
            step();
            chk("steady_count", fifo_count, 15);
        end
        s_valid = 0;
        chk("steady_reads", rd_log.size() >= 10, 1);
        for (int i = 1; i < rd_log.size(); i++)
            chk("steady_interval", rd_log[i] - rd_log[i-1], 5);

        // Low fill: period 6, then underflow at the first tick on empty.
        do_reset();
        preload(5);
        fifo_out_en = 1; rd_log.delete();
        for (int i = 0; i < 45; i++) step();
        chk("low_reads", rd_log.size(), 5);
        for (int i = 1; i < rd_log.size(); i++)
            chk("low_interval", rd_log[i] - rd_log[i-1], 6);
        chk("udf_after_empty", udf_flag, 1);

        // High fill: period 4 while fill >= 22 at the read, then 5.
        do_reset();
        preload(25);
        fifo_out_en = 1; rd_log.delete();
        for (int i = 0; i < 60; i++) step();
        chk("high_reads", rd_log.size() >= 10, 1);
        for (int i = 1; i < rd_log.size(); i++)
            chk("high_interval", rd_log[i] - rd_log[i-1], ((25 - (i - 1)) >= 22) ? 4 : 5);

        // Fractional mode at mid fill: periods alternate 5 and 6.
        frac_mode = 1; valid_delay_sel = 1;
        do_reset();
        preload(15);
        fifo_out_en = 1; rd_log.delete();
        for (int i = 0; i < 66; i++) begin
            s_valid = (m_cnt == 0); s_iq = {$urandom, $urandom};
            step();
        end
        s_valid = 0;
        chk("frac_reads", rd_log.size() >= 10, 1);
        for (int i = 2; i < rd_log.size(); i++) begin
            chk("frac_pair", (rd_log[i] - rd_log[i-1]) + (rd_log[i-1] - rd_log[i-2]), 11);
            chk("frac_alt", (rd_log[i] - rd_log[i-1]) != (rd_log[i-1] - rd_log[i-2]), 1);
        end
        frac_mode = 0; valid_delay_sel = 0;

        // Overflow on a full FIFO, flag clear, then bypass drain.
        do_reset();
        preload(32);
        chk("full_count", fifo_count, 32);
        s_valid = 1; fifo_in_en = 1; s_iq = 64'hDEAD_BEEF_0BAD_F00D;
        step();
        s_valid = 0;
        step();
        chk("ovf_set", ovf_flag, 1);
        chk("ovf_cnt_one", ovf_cnt, STATS ? 64'd1 : 64'd0);
        chk("ovf_count_held", fifo_count, 32);
        clear_flags = 1; step(); clear_flags = 0; step();
        chk("ovf_cleared", ovf_flag, 0);
        chk("ovf_cnt_cleared", ovf_cnt, 0);
        fifo_out_en = 1; pace_bypass = 1; rd_log.delete();
        for (int i = 0; i < 40; i++) step();
        chk("bypass_reads", rd_log.size(), 32);
        if (rd_log.size() == 32) chk("bypass_span", rd_log[31] - rd_log[0], 31);
        chk("bypass_no_udf", udf_flag, 0);
        pace_bypass = 0;

        // Reset with stored data, then a fresh sample passes unchanged.
        do_reset();
        preload(10);
        rst = 1; step(); rst = 0;
        chk("midrst_count", fifo_count, 0);
        chk("midrst_m_valid", m_valid, 0);
        fifo_out_en = 1; fifo_in_en = 1; s_valid = 1; s_iq = 64'h0123_4567_89AB_CDEF;
        step();
        s_valid = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (m_valid === 1'b1) begin
                seen++;
                chk("midrst_first", m_iq, 64'h0123_4567_89AB_CDEF);
            end
        end
        chk("midrst_seen", seen, 1);

        // Randomized traffic, register settings and saturating periods.
        for (int blk = 0; blk < 8; blk++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0: count_top_nom = 0;
                1: count_top_nom = 1;
                2: count_top_nom = 2;
                3: count_top_nom = 4;
                4: count_top_nom = 7;
                5: count_top_nom = 62;
                default: count_top_nom = 63;
            endcase
            frac_mode   = $urandom_range(0, 1);
            low_thresh  = FCW'($urandom_range(0, 33));
            high_thresh = FCW'($urandom_range(0, 33));
            pv = (blk % 3 == 0) ? 90 : ((blk % 3 == 1) ? 15 : 50);
            po = (blk % 3 == 0) ? 30 : 90;
            for (int i = 0; i < 200; i++) begin
                rst             = ($urandom_range(0, 999) < 5);
                s_valid         = ($urandom_range(0, 99) < pv);
                s_iq            = {$urandom, $urandom};
                fifo_in_en      = ($urandom_range(0, 99) < 90);
                fifo_out_en     = ($urandom_range(0, 99) < po);
                pace_bypass     = ($urandom_range(0, 99) < 5);
                valid_delay_sel = $urandom_range(0, 1);
                clear_flags     = ($urandom_range(0, 99) < 3);
                step();
            end
        end
        rst = 0;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
